// File: rtl/sldma350_str_in_buffer.sv
// ---------------------------------------------------------------------------
// sldma350_str_in_buffer
// Upstream feeder for one DMA350 stream-in channel. An accelerator AXI-Stream
// source is buffered in a show-ahead FIFO and presented to the DMAC stream-in
// port. Trigger-in requests are raised when enough data (or a packet tail) is
// buffered. A DMAC flush drops the rest of the current packet.
//
// Ports
//   SYS_HCLK / SYS_HRESET       clock, asynchronous active-high reset
//   SRC_T*                      upstream AXI-Stream slave (data/strb/last)
//   STR_T*                      stream to DMAC str_in_N (show-ahead head entry)
//   STR_FLUSH                   DMAC flush request (edge-detected)
//   TRIG_REQ / TRIG_REQ_TYPE    trigger request to DMAC (10 block, 11 last block)
//   TRIG_ACK / TRIG_ACK_TYPE    trigger ack (00 ok, 01 deny, 10 flush)
//   LEVEL                       FIFO occupancy in beats
//   DROP_CNT                    beats discarded by flush, saturating
//   DBG_DP_STATE                data path FSM state (0 PASS, 1 DRAIN)
//   DBG_TRIG_STATE              trigger FSM state (0 T_IDLE, 1 T_REQ, 2 T_WAIT)
//
// Handshakes: a beat transfers on a rising clock edge where VALID and READY
// are both 1. VALID never waits on READY; the source side READY is derived
// only from registered state, STR_FLUSH and the trigger ack, never STR_TREADY.
// ---------------------------------------------------------------------------
module sldma350_str_in_buffer #(
  parameter int DATA_W      = 128,
  parameter int STRB_W      = 16,
  parameter int DEPTH       = 8,
  parameter int TRIG_THRESH = 4
) (
  input  logic                     SYS_HCLK,
  input  logic                     SYS_HRESET,
  input  logic                     SRC_TVALID,
  output logic                     SRC_TREADY,
  input  logic [DATA_W-1:0]        SRC_TDATA,
  input  logic [STRB_W-1:0]        SRC_TSTRB,
  input  logic                     SRC_TLAST,
  output logic                     STR_TVALID,
  input  logic                     STR_TREADY,
  output logic [DATA_W-1:0]        STR_TDATA,
  output logic [STRB_W-1:0]        STR_TSTRB,
  output logic                     STR_TLAST,
  input  logic                     STR_FLUSH,
  output logic                     TRIG_REQ,
  output logic [1:0]               TRIG_REQ_TYPE,
  input  logic                     TRIG_ACK,
  input  logic [1:0]               TRIG_ACK_TYPE,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [15:0]              DROP_CNT,
  output logic                     DBG_DP_STATE,
  output logic [1:0]               DBG_TRIG_STATE
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {DP_PASS = 1'b0, DP_DRAIN = 1'b1} dp_state_e;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_WAIT = 2'd2} trig_state_e;

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [STRB_W-1:0] strb_mem_q [DEPTH];
  logic [DEPTH-1:0]  last_mem_q;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] last_cnt_q, last_cnt_d;
  logic [LW-1:0] consumed_q;
  logic [LW-1:0] drop_add;
  logic [16:0]   drop_sum;
  logic [15:0]   drop_q;
  logic          flush_q;
  dp_state_e     dp_state_q;
  trig_state_e   trig_state_q;
  logic          trig_req_q;
  logic [1:0]    req_type_q;

  logic full, empty, dp_pass, flush_evt, flush_take;
  logic push, pop, drain_beat, head_last, tail_buffered;

  assign dp_pass    = (dp_state_q == DP_PASS);
  assign full       = (count_q == LW'(DEPTH));
  assign empty      = (count_q == '0);
  // STR_FLUSH held high counts once; an ack of type flush is its own event.
  assign flush_evt  = (STR_FLUSH & ~flush_q) | (TRIG_ACK & (TRIG_ACK_TYPE == 2'b10));
  assign flush_take = flush_evt & dp_pass;

  // The source is held off in the flush cycle so no beat slips past the clear.
  assign SRC_TREADY = ~SYS_HRESET & (dp_pass ? (~full & ~flush_take) : 1'b1);
  assign STR_TVALID = dp_pass & ~empty;
  assign STR_TDATA  = STR_TVALID ? data_mem_q[rd_ptr_q] : '0;
  assign STR_TSTRB  = STR_TVALID ? strb_mem_q[rd_ptr_q] : '0;
  assign head_last  = last_mem_q[rd_ptr_q];
  assign STR_TLAST  = STR_TVALID & head_last;

  assign push       = SRC_TVALID & SRC_TREADY & dp_pass;
  assign pop        = STR_TVALID & STR_TREADY;
  assign drain_beat = SRC_TVALID & ~dp_pass;

  assign count_d    = flush_take ? '0 : count_q + LW'(push) - LW'(pop);
  assign last_cnt_d = flush_take ? '0 :
                      last_cnt_q + LW'(push & SRC_TLAST) - LW'(pop & head_last);
  // A tail still buffered after this cycle's pop means the packet already ended.
  assign tail_buffered = (last_cnt_q > LW'(pop & head_last));

  assign drop_add = flush_take ? (count_q - LW'(pop)) : LW'(drain_beat);
  assign drop_sum = {1'b0, drop_q} + 17'(drop_add);

  assign LEVEL          = count_q;
  assign DROP_CNT       = drop_q;
  assign TRIG_REQ       = trig_req_q;
  assign TRIG_REQ_TYPE  = req_type_q;
  assign DBG_DP_STATE   = dp_state_q;
  assign DBG_TRIG_STATE = trig_state_q;

  // Storage needs no reset: outputs are masked by STR_TVALID.
  always_ff @(posedge SYS_HCLK) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= SRC_TDATA;
      strb_mem_q[wr_ptr_q] <= SRC_TSTRB;
      last_mem_q[wr_ptr_q] <= SRC_TLAST;
    end
  end

  // FIFO pointers, counters and data path FSM.
  always_ff @(posedge SYS_HCLK or posedge SYS_HRESET) begin
    if (SYS_HRESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_cnt_q <= '0;
      drop_q     <= '0;
      flush_q    <= 1'b0;
      dp_state_q <= DP_PASS;
    end else begin
      flush_q    <= STR_FLUSH;
      count_q    <= count_d;
      last_cnt_q <= last_cnt_d;
      drop_q     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (flush_take) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case (dp_state_q)
        DP_PASS:  if (flush_take && !tail_buffered) dp_state_q <= DP_DRAIN;
        DP_DRAIN: if (drain_beat && SRC_TLAST)      dp_state_q <= DP_PASS;
        default:  dp_state_q <= DP_PASS;
      endcase
    end
  end

  // Trigger FSM. Requests are evaluated on next-cycle occupancy so TRIG_REQ
  // rises the cycle after the push that meets the condition.
  always_ff @(posedge SYS_HCLK or posedge SYS_HRESET) begin
    if (SYS_HRESET) begin
      trig_state_q <= T_IDLE;
      trig_req_q   <= 1'b0;
      req_type_q   <= 2'b00;
      consumed_q   <= '0;
    end else begin
      case (trig_state_q)
        T_IDLE: begin
          if (dp_pass && !flush_evt) begin
            if (last_cnt_d != '0) begin
              trig_state_q <= T_REQ;
              trig_req_q   <= 1'b1;
              req_type_q   <= 2'b11;
            end else if (count_d >= LW'(TRIG_THRESH)) begin
              trig_state_q <= T_REQ;
              trig_req_q   <= 1'b1;
              req_type_q   <= 2'b10;
            end
          end
        end
        T_REQ: begin
          if (TRIG_ACK) begin
            trig_req_q <= 1'b0;
            consumed_q <= '0;
            trig_state_q <= (TRIG_ACK_TYPE == 2'b00) ? T_WAIT : T_IDLE;
          end
        end
        T_WAIT: begin
          if (flush_evt) begin
            trig_state_q <= T_IDLE;
          end else if (pop) begin
            consumed_q <= consumed_q + 1'b1;
            if (req_type_q == 2'b11) begin
              if (head_last) trig_state_q <= T_IDLE;
            end else if (consumed_q == LW'(TRIG_THRESH - 1)) begin
              trig_state_q <= T_IDLE;
            end
          end
        end
        default: begin
          trig_state_q <= T_IDLE;
          trig_req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sldma350_str_in_buffer.sv
// ---------------------------------------------------------------------------
// tb_sldma350_str_in_buffer
// Directed bench for sldma350_str_in_buffer with default parameters
// (DATA_W 128, DEPTH 8, TRIG_THRESH 4). Inputs change 1 time unit after
// each rising edge; outputs are checked at that same point, after state settles.
// ---------------------------------------------------------------------------
module tb_sldma350_str_in_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         src_tvalid, src_tready, src_tlast;
  logic [127:0] src_tdata;
  logic [15:0]  src_tstrb;
  logic         str_tvalid, str_tready, str_tlast, str_flush;
  logic [127:0] str_tdata;
  logic [15:0]  str_tstrb;
  logic         trig_req, trig_ack;
  logic [1:0]   trig_req_type, trig_ack_type;
  logic [3:0]   level;
  logic [15:0]  drop_cnt;
  logic         dbg_dp_state;
  logic [1:0]   dbg_trig_state;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sldma350_str_in_buffer dut (
    .SYS_HCLK(clk), .SYS_HRESET(rst),
    .SRC_TVALID(src_tvalid), .SRC_TREADY(src_tready), .SRC_TDATA(src_tdata),
    .SRC_TSTRB(src_tstrb), .SRC_TLAST(src_tlast),
    .STR_TVALID(str_tvalid), .STR_TREADY(str_tready), .STR_TDATA(str_tdata),
    .STR_TSTRB(str_tstrb), .STR_TLAST(str_tlast), .STR_FLUSH(str_flush),
    .TRIG_REQ(trig_req), .TRIG_REQ_TYPE(trig_req_type),
    .TRIG_ACK(trig_ack), .TRIG_ACK_TYPE(trig_ack_type),
    .LEVEL(level), .DROP_CNT(drop_cnt),
    .DBG_DP_STATE(dbg_dp_state), .DBG_TRIG_STATE(dbg_trig_state)
  );

  function automatic logic [127:0] pat(input int i);
    return {32'hC0DE0000 | 32'(i), ~32'(i), 32'(i * 3), 32'(i)};
  endfunction

  function automatic logic [15:0] spat(input int i);
    return 16'hF0F0 ^ 16'(i);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_tvalid = 0; src_tdata = '0; src_tstrb = '0; src_tlast = 0;
    str_tready = 0; str_flush = 0; trig_ack = 0; trig_ack_type = 2'b00;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic push_beat(input int i, input logic last);
    src_tvalid = 1'b1;
    src_tdata  = pat(i);
    src_tstrb  = spat(i);
    src_tlast  = last;
    step();
    src_tvalid = 1'b0;
    src_tlast  = 1'b0;
  endtask

  task automatic ack(input logic [1:0] t);
    trig_ack = 1'b1;
    trig_ack_type = t;
    step();
    trig_ack = 1'b0;
    trig_ack_type = 2'b00;
  endtask

  // Pops one beat, checking the head against the expected index and TLAST.
  task automatic pop_chk(input string tag, input int i, input logic last);
    str_tready = 1'b1;
    chk({tag, "_valid"}, 128'(str_tvalid), 128'(1));
    chk({tag, "_data"}, str_tdata, pat(i));
    chk({tag, "_strb"}, 128'(str_tstrb), 128'(spat(i)));
    chk({tag, "_last"}, 128'(str_tlast), 128'(last));
    step();
    str_tready = 1'b0;
  endtask

  initial begin
    // reset state, observed while reset is still asserted
    rst = 1'b1;
    src_tvalid = 0; src_tdata = '0; src_tstrb = '0; src_tlast = 0;
    str_tready = 0; str_flush = 0; trig_ack = 0; trig_ack_type = 2'b00;
    step(); step();
    chk("rst_src_tready", 128'(src_tready), 128'(0));
    chk("rst_str_tvalid", 128'(str_tvalid), 128'(0));
    chk("rst_str_tdata", str_tdata, 128'(0));
    chk("rst_trig_req", 128'(trig_req), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_drop", 128'(drop_cnt), 128'(0));
    rst = 1'b0;
    step();
    chk("post_rst_src_tready", 128'(src_tready), 128'(1));

    // 1: block request at threshold, ack ok, four pops return to idle
    push_beat(0, 0); push_beat(1, 0); push_beat(2, 0);
    chk("t1_level3", 128'(level), 128'(3));
    chk("t1_req_below", 128'(trig_req), 128'(0));
    chk("t1_first_beat", str_tdata, pat(0));
    push_beat(3, 0);
    chk("t1_req_at", 128'(trig_req), 128'(1));
    chk("t1_req_type", 128'(trig_req_type), 128'(2'b10));
    ack(2'b00);
    chk("t1_req_after_ack", 128'(trig_req), 128'(0));
    chk("t1_wait", 128'(dbg_trig_state), 128'(2));
    pop_chk("t1_pop0", 0, 0); pop_chk("t1_pop1", 1, 0); pop_chk("t1_pop2", 2, 0);
    chk("t1_still_wait", 128'(dbg_trig_state), 128'(2));
    pop_chk("t1_pop3", 3, 0);
    chk("t1_idle", 128'(dbg_trig_state), 128'(0));
    chk("t1_empty", 128'(str_tvalid), 128'(0));

    // 2: packet tail raises a last-block request
    do_reset();
    push_beat(10, 0);
    chk("t2_req_none", 128'(trig_req), 128'(0));
    push_beat(11, 1);
    chk("t2_req", 128'(trig_req), 128'(1));
    chk("t2_req_type", 128'(trig_req_type), 128'(2'b11));
    ack(2'b00);
    chk("t2_req_after_ack", 128'(trig_req), 128'(0));
    pop_chk("t2_pop0", 10, 0);
    pop_chk("t2_pop1", 11, 1);
    chk("t2_idle", 128'(dbg_trig_state), 128'(0));
    step();
    chk("t2_req_stays_low", 128'(trig_req), 128'(0));

    // 3: fill to full with sink stalled, then drain in order
    do_reset();
    for (int i = 0; i < 8; i++) push_beat(i, 0);
    chk("t3_full_ready", 128'(src_tready), 128'(0));
    chk("t3_level8", 128'(level), 128'(8));
    str_tready = 1'b1;
    #1;
    chk("t3_full_ready_while_pop", 128'(src_tready), 128'(0));
    for (int i = 0; i < 8; i++) pop_chk("t3_pop", i, 0);
    chk("t3_level0", 128'(level), 128'(0));

    // 5: deny drops the request for one cycle, then it returns
    do_reset();
    for (int i = 0; i < 4; i++) push_beat(20 + i, 0);
    chk("t5_req", 128'(trig_req), 128'(1));
    ack(2'b01);
    chk("t5_req_low", 128'(trig_req), 128'(0));
    step();
    chk("t5_req_again", 128'(trig_req), 128'(1));
    chk("t5_req_type", 128'(trig_req_type), 128'(2'b10));

    // 4: flush with no tail buffered, drain to packet end
    do_reset();
    for (int i = 0; i < 5; i++) push_beat(30 + i, 0);
    chk("t4_level5", 128'(level), 128'(5));
    str_flush = 1'b1;
    step();
    chk("t4_tvalid_off", 128'(str_tvalid), 128'(0));
    chk("t4_drop5", 128'(drop_cnt), 128'(5));
    chk("t4_drain", 128'(dbg_dp_state), 128'(1));
    chk("t4_drain_ready", 128'(src_tready), 128'(1));
    push_beat(40, 0);
    chk("t4_drop6", 128'(drop_cnt), 128'(6));
    push_beat(41, 0);
    push_beat(42, 1);
    chk("t4_drop8", 128'(drop_cnt), 128'(8));
    chk("t4_pass", 128'(dbg_dp_state), 128'(0));
    chk("t4_level_after", 128'(level), 128'(0));
    step();
    chk("t4_held_flush_once", 128'(dbg_dp_state), 128'(0));
    str_flush = 1'b0;
    push_beat(50, 0);
    push_beat(51, 1);
    chk("t4_next_level", 128'(level), 128'(2));
    pop_chk("t4_next0", 50, 0);
    pop_chk("t4_next1", 51, 1);
    chk("t4_drop_kept", 128'(drop_cnt), 128'(8));

    // 6: reset mid-packet aborts everything
    for (int i = 0; i < 6; i++) push_beat(60 + i, 0);
    chk("t6_level6", 128'(level), 128'(6));
    chk("t6_req", 128'(trig_req), 128'(1));
    rst = 1'b1;
    step();
    chk("t6_src_tready", 128'(src_tready), 128'(0));
    chk("t6_str_tvalid", 128'(str_tvalid), 128'(0));
    chk("t6_str_tdata", str_tdata, 128'(0));
    chk("t6_trig_req", 128'(trig_req), 128'(0));
    chk("t6_trig_type", 128'(trig_req_type), 128'(0));
    chk("t6_level", 128'(level), 128'(0));
    chk("t6_drop", 128'(drop_cnt), 128'(0));
    rst = 1'b0;
    step();
    push_beat(70, 0);
    push_beat(71, 1);
    chk("t6_new_req_type", 128'(trig_req_type), 128'(2'b11));
    pop_chk("t6_new0", 70, 0);
    pop_chk("t6_new1", 71, 1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
